// File: rtl/half_duplex_bus_ctrl.sv
// rtl/half_duplex_bus_ctrl.sv - strobed half-duplex write/read engine for the shared target bus.
// Optional macro SYNC2_EN: 2-flop pad_din synchronizer plus a 2-cycle WAIT before read capture.
module half_duplex_bus_ctrl #(
  parameter int DATA_W     = 8,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 2,
  parameter int TURN_CYC   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] pad_dout,
  output logic              pad_oe,
  input  logic [DATA_W-1:0] pad_din,
  output logic              io_stb,
  output logic              io_rw
);

  localparam int MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int CNT_MAX = (MAX_SS > TURN_CYC) ? MAX_SS : TURN_CYC;
  // Counter holds (phase length - 1); at least 1 bit so the WAIT phase can count 2 cycles.
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_TURN,
`ifdef SYNC2_EN
    S_WAIT,
`endif
    S_DONE
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] pad_dout_q;
  logic              pad_oe_q;
  logic              io_stb_q;
  logic              io_rw_q;
  logic              busy_q;
  logic              done_q;

`ifdef SYNC2_EN
  logic [DATA_W-1:0] sync1_q;
  logic [DATA_W-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pad_din;
      sync2_q <= sync1_q;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      pad_dout_q <= '0;
      pad_oe_q   <= 1'b0;
      io_stb_q   <= 1'b0;
      io_rw_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            we_q    <= we;
            busy_q  <= 1'b1;
            io_rw_q <= ~we;
            if (we) begin
              pad_dout_q <= wdata;
              pad_oe_q   <= 1'b1;
              cnt_q      <= SETUP_LOAD;
              state_q    <= S_SETUP;
            end else begin
              cnt_q   <= TURN_LOAD;
              state_q <= S_TURN;
            end
          end
        end

        S_SETUP, S_TURN: begin
          if (cnt_q == '0) begin
            io_stb_q <= 1'b1;
            cnt_q    <= STROBE_LOAD;
            state_q  <= S_STROBE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_STROBE: begin
          if (cnt_q == '0) begin
            io_stb_q <= 1'b0;
            if (we_q) begin
              state_q <= S_HOLD;
            end else begin
`ifdef SYNC2_EN
              cnt_q   <= CNT_W'(1);
              state_q <= S_WAIT;
`else
              // pad_din is only looked at here, while the target still drives it.
              rdata_q <= pad_din;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
`endif
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_HOLD: begin
          pad_oe_q <= 1'b0;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_DONE;
        end

`ifdef SYNC2_EN
        S_WAIT: begin
          if (cnt_q == '0) begin
            rdata_q <= sync2_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`endif

        S_DONE: begin
          io_rw_q <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          pad_oe_q <= 1'b0;
          io_stb_q <= 1'b0;
          io_rw_q  <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pad_dout = pad_dout_q;
  assign pad_oe   = pad_oe_q;
  assign io_stb   = io_stb_q;
  assign io_rw    = io_rw_q;

endmodule

// File: tb/tb_half_duplex_bus_ctrl.sv
// tb/tb_half_duplex_bus_ctrl.sv - directed bench for half_duplex_bus_ctrl (default and overridden timing).
module tb_half_duplex_bus_ctrl;

`ifdef SYNC2_EN
  localparam int RD_LAT = 7;
`else
  localparam int RD_LAT = 5;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       a_req, a_we, a_busy, a_done, a_pad_oe, a_io_stb, a_io_rw;
  logic [7:0] a_wdata, a_rdata, a_pad_dout, a_pad_din;
  logic       b_req, b_we, b_busy, b_done, b_pad_oe, b_io_stb, b_io_rw;
  logic [7:0] b_wdata, b_rdata, b_pad_dout, b_pad_din;

  // Target models: drive the bus only while strobed.
  assign a_pad_din = a_io_stb ? 8'h3C : 8'hxx;
  assign b_pad_din = b_io_stb ? 8'hC3 : 8'hxx;

  half_duplex_bus_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .req(a_req), .we(a_we), .wdata(a_wdata),
    .rdata(a_rdata), .busy(a_busy), .done(a_done), .pad_dout(a_pad_dout),
    .pad_oe(a_pad_oe), .pad_din(a_pad_din), .io_stb(a_io_stb), .io_rw(a_io_rw)
  );

  half_duplex_bus_ctrl #(.DATA_W(8), .SETUP_CYC(1), .STROBE_CYC(3), .TURN_CYC(1)) u_b (
    .clk(clk), .rst_n(rst_n), .req(b_req), .we(b_we), .wdata(b_wdata),
    .rdata(b_rdata), .busy(b_busy), .done(b_done), .pad_dout(b_pad_dout),
    .pad_oe(b_pad_oe), .pad_din(b_pad_din), .io_stb(b_io_stb), .io_rw(b_io_rw)
  );

  int checks = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert (((a_pad_oe & a_io_rw) === 1'b0) && ((b_pad_oe & b_io_rw) === 1'b0)) else begin
        failures++;
        $error("FAIL oe_rw_overlap observed a=%b b=%b expected=0", a_pad_oe & a_io_rw, b_pad_oe & b_io_rw);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int ndone, last_rstb, first_oe, rel_cnt, wr_done_seen;

  initial begin
    rst_n = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_wdata = 8'h00;
    b_req = 1'b0; b_we = 1'b0; b_wdata = 8'h00;
    #3 rst_n = 1'b0;
    step();
    step();
    chk1("rst_oe", a_pad_oe, 1'b0);
    chk1("rst_stb", a_io_stb, 1'b0);
    chk1("rst_rw", a_io_rw, 1'b0);
    chk1("rst_busy", a_busy, 1'b0);
    chk1("rst_done", a_done, 1'b0);
    chk8("rst_dout", a_pad_dout, 8'h00);
    chk8("rst_rdata", a_rdata, 8'h00);
    chk1("rst_b_busy", b_busy, 1'b0);
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;

    // Write A5, req at cycle N.
    a_req = 1'b1; a_we = 1'b1; a_wdata = 8'hA5;
    for (int k = 1; k <= 7; k++) begin
      step();
      a_req = 1'b0; a_wdata = 8'h00;
      chk1("wr_oe", a_pad_oe, k <= 5);
      chk8("wr_dout", a_pad_dout, 8'hA5);
      chk1("wr_stb", a_io_stb, (k == 3) || (k == 4));
      chk1("wr_rw", a_io_rw, 1'b0);
      chk1("wr_busy", a_busy, k <= 5);
      chk1("wr_done", a_done, k == 6);
    end

    // Read 3C.
    a_req = 1'b1; a_we = 1'b0;
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      step();
      a_req = 1'b0;
      chk1("rd_oe", a_pad_oe, 1'b0);
      chk1("rd_rw", a_io_rw, k <= RD_LAT);
      chk1("rd_stb", a_io_stb, (k == 3) || (k == 4));
      chk1("rd_done", a_done, k == RD_LAT);
      chk1("rd_busy", a_busy, k < RD_LAT);
      if (k == RD_LAT) chk8("rd_rdata", a_rdata, 8'h3C);
    end
    chk8("rd_rdata_hold", a_rdata, 8'h3C);
    chk8("rd_dout_hold", a_pad_dout, 8'hA5);

    // Write 5A with a stray read req during SETUP.
    a_req = 1'b1; a_we = 1'b1; a_wdata = 8'h5A;
    ndone = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 2) begin
        a_req = 1'b1; a_we = 1'b0; a_wdata = 8'hFF;
      end else begin
        a_req = 1'b0; a_wdata = 8'h00;
      end
      if (a_done) ndone++;
      if (k == 6) chk1("ign_done_at6", a_done, 1'b1);
      if (a_pad_oe) chk8("ign_dout", a_pad_dout, 8'h5A);
    end
    chki("ign_ndone", ndone, 1);
    chk8("ign_dout_end", a_pad_dout, 8'h5A);
    chk8("ign_rdata", a_rdata, 8'h3C);

    // Asynchronous reset mid-STROBE of a write.
    a_req = 1'b1; a_we = 1'b1; a_wdata = 8'h96;
    step(); a_req = 1'b0;
    step();
    step();
    chk1("ar_stb_pre", a_io_stb, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("ar_oe", a_pad_oe, 1'b0);
    chk1("ar_stb", a_io_stb, 1'b0);
    chk1("ar_busy", a_busy, 1'b0);
    chk8("ar_rdata", a_rdata, 8'h00);
    step();
    step();
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (a_done) ndone++;
    end
    chki("ar_no_done", ndone, 0);
    a_req = 1'b1; a_we = 1'b1; a_wdata = 8'h77;
    for (int k = 1; k <= 7; k++) begin
      step();
      a_req = 1'b0;
      chk1("ar_wr_done", a_done, k == 6);
      if (k == 5) chk1("ar_wr_oe5", a_pad_oe, 1'b1);
      if (k == 6) chk1("ar_wr_oe6", a_pad_oe, 1'b0);
    end
    chk8("ar_wr_dout", a_pad_dout, 8'h77);

    // Read then write back-to-back with req held high.
    a_req = 1'b1; a_we = 1'b0; a_wdata = 8'hE1;
    last_rstb = -1; first_oe = -1; rel_cnt = 0;
    for (int k = 1; k <= 30 && first_oe < 0; k++) begin
      step();
      if (k == 1) a_we = 1'b1;
      if (a_io_stb && a_io_rw) last_rstb = k;
      if (a_pad_oe) first_oe = k;
      else if (last_rstb > 0 && !a_io_stb && k > last_rstb) rel_cnt++;
    end
    a_req = 1'b0;
    chki("b2b_last_rstb", last_rstb, 4);
    chki("b2b_first_oe", first_oe, RD_LAT + 2);
    chk1("b2b_released_ge2", rel_cnt >= 2, 1'b1);
    chk8("b2b_rdata", a_rdata, 8'h3C);
    wr_done_seen = 0;
    for (int k = 1; k <= 10 && wr_done_seen == 0; k++) begin
      step();
      if (a_done) wr_done_seen = k;
    end
    chki("b2b_wr_done", wr_done_seen, 5);
    chk8("b2b_wr_dout", a_pad_dout, 8'hE1);

    // Overridden timing: SETUP=1, STROBE=3, TURN=1.
    b_req = 1'b1; b_we = 1'b1; b_wdata = 8'h4B;
    for (int k = 1; k <= 7; k++) begin
      step();
      b_req = 1'b0;
      chk1("p_wr_oe", b_pad_oe, k <= 5);
      chk1("p_wr_stb", b_io_stb, (k >= 2) && (k <= 4));
      chk1("p_wr_done", b_done, k == 6);
    end
    chk8("p_wr_dout", b_pad_dout, 8'h4B);
    b_req = 1'b1; b_we = 1'b0;
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      step();
      b_req = 1'b0;
      chk1("p_rd_oe", b_pad_oe, 1'b0);
      chk1("p_rd_stb", b_io_stb, (k >= 2) && (k <= 4));
      chk1("p_rd_done", b_done, k == RD_LAT);
      if (k == RD_LAT) chk8("p_rd_rdata", b_rdata, 8'hC3);
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
